// File: rtl/dyser_pkg.sv
// Shared defaults and helpers for the DySER port queue bank.
package dyser_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int NPORT_DEF  = 8;
  localparam int NLANE_DEF  = 2;

  typedef logic [2:0] port_idx_t;

  // Elaboration-time ceil(log2(v)); v <= 1 yields 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/dyser_port_queue_if.sv
// Core-facing send/recv lanes, flush and occupancy for one port queue bank.
interface dyser_port_queue_if #(
  parameter int DATA_W = dyser_pkg::DATA_W_DEF,
  parameter int NPORT  = dyser_pkg::NPORT_DEF,
  parameter int DEPTH  = 4,
  parameter int NLANE  = dyser_pkg::NLANE_DEF
) ();
  localparam int PORT_W = dyser_pkg::clog2(NPORT);
  localparam int CNT_W  = dyser_pkg::clog2(DEPTH) + 1;

  logic                      flush;
  logic [NLANE-1:0]          send_en;
  logic [NLANE*PORT_W-1:0]   send_port;
  logic [NLANE*DATA_W-1:0]   send_data;
  logic                      send_stall;
  logic [NLANE-1:0]          recv_en;
  logic [NLANE*PORT_W-1:0]   recv_port;
  logic [NLANE*DATA_W-1:0]   recv_data;
  logic                      recv_stall;
  logic [NPORT*CNT_W-1:0]    occ;

  modport master (
    output flush, send_en, send_port, send_data, recv_en, recv_port,
    input  send_stall, recv_data, recv_stall, occ
  );

  modport slave (
    input  flush, send_en, send_port, send_data, recv_en, recv_port,
    output send_stall, recv_data, recv_stall, occ
  );
endinterface

// File: rtl/dyser_port_fifo.sv
// One port's circular buffer: writes up to NLANE words and pops up to NLANE words per cycle.
module dyser_port_fifo import dyser_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4,
  parameter int NLANE  = NLANE_DEF,
  localparam int PTR_W = clog2(DEPTH),
  localparam int CNT_W = clog2(DEPTH) + 1,
  localparam int LC_W  = clog2(NLANE + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic [LC_W-1:0]               wr_cnt,
  input  logic [NLANE-1:0][DATA_W-1:0]  wr_data,
  input  logic [LC_W-1:0]               rd_cnt,
  output logic [NLANE-1:0][DATA_W-1:0]  head,
  output logic [CNT_W-1:0]              count
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  // Callers only issue counts that fit, so pointers and count wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      for (int k = 0; k < NLANE; k++) begin
        if (k < int'(wr_cnt)) mem[PTR_W'(int'(wr_ptr) + k)] <= wr_data[k];
      end
      wr_ptr <= wr_ptr + PTR_W'(wr_cnt);
      rd_ptr <= rd_ptr + PTR_W'(rd_cnt);
      count  <= count + CNT_W'(wr_cnt) - CNT_W'(rd_cnt);
    end
  end

  for (genvar gi = 0; gi < NLANE; gi++) begin : g_head
    assign head[gi] = mem[PTR_W'(int'(rd_ptr) + gi)];
  end

endmodule

// File: rtl/dyser_port_queue.sv
// Bank of per-port FIFOs with all-or-nothing multi-lane send/recv and synchronous flush.
module dyser_port_queue import dyser_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NPORT  = NPORT_DEF,
  parameter int DEPTH  = 4,
  parameter int NLANE  = NLANE_DEF
) (
  input logic                clk,
  input logic                rst_n,
  dyser_port_queue_if.slave  bus
);
  localparam int PORT_W = clog2(NPORT);
  localparam int CNT_W  = clog2(DEPTH) + 1;
  localparam int LC_W   = clog2(NLANE + 1);
  localparam int LI_W   = (NLANE > 1) ? clog2(NLANE) : 1;

  logic [NPORT-1:0][LC_W-1:0]              need, want, wr_cnt, rd_cnt;
  logic [NPORT-1:0][NLANE-1:0][DATA_W-1:0] wr_data, head;
  logic [NPORT-1:0][CNT_W-1:0]             count;
  logic [NLANE*DATA_W-1:0]                 recv_data;
  logic send_over, recv_over, send_stall, recv_stall;

  // Lane crossbars: a lane's slot within its port is the number of lower enabled lanes on that port.
  always_comb begin
    logic [PORT_W-1:0] sp_i, sp_j, rp_i, rp_j;
    logic [LI_W-1:0]   ks, kr;
    need      = '0;
    want      = '0;
    wr_data   = '0;
    recv_data = '0;
    sp_i = '0; sp_j = '0; rp_i = '0; rp_j = '0;
    ks = '0; kr = '0;
    for (int i = 0; i < NLANE; i++) begin
      sp_i = bus.send_port[i*PORT_W +: PORT_W];
      rp_i = bus.recv_port[i*PORT_W +: PORT_W];
      ks = '0;
      kr = '0;
      for (int j = 0; j < i; j++) begin
        sp_j = bus.send_port[j*PORT_W +: PORT_W];
        rp_j = bus.recv_port[j*PORT_W +: PORT_W];
        if (bus.send_en[j] && sp_j == sp_i) ks = ks + LI_W'(1);
        if (bus.recv_en[j] && rp_j == rp_i) kr = kr + LI_W'(1);
      end
      if (bus.send_en[i]) begin
        need[sp_i]        = need[sp_i] + LC_W'(1);
        wr_data[sp_i][ks] = bus.send_data[i*DATA_W +: DATA_W];
      end
      if (bus.recv_en[i]) want[rp_i] = want[rp_i] + LC_W'(1);
      recv_data[i*DATA_W +: DATA_W] = head[rp_i][kr];
    end
  end

  // Space and data checks use only registered counts, keeping send and recv independent.
  always_comb begin
    send_over = 1'b0;
    recv_over = 1'b0;
    for (int p = 0; p < NPORT; p++) begin
      if (int'(need[p]) > DEPTH - int'(count[p])) send_over = 1'b1;
      if (int'(want[p]) > int'(count[p]))         recv_over = 1'b1;
    end
  end

  assign send_stall     = ((|bus.send_en) && send_over) || bus.flush;
  assign recv_stall     = ((|bus.recv_en) && recv_over) || bus.flush;
  assign bus.send_stall = send_stall;
  assign bus.recv_stall = recv_stall;
  assign bus.recv_data  = recv_data;

  for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
    assign wr_cnt[gi] = send_stall ? '0 : need[gi];
    assign rd_cnt[gi] = recv_stall ? '0 : want[gi];

    dyser_port_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .NLANE  (NLANE)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (bus.flush),
      .wr_cnt  (wr_cnt[gi]),
      .wr_data (wr_data[gi]),
      .rd_cnt  (rd_cnt[gi]),
      .head    (head[gi]),
      .count   (count[gi])
    );

    assign bus.occ[gi*CNT_W +: CNT_W] = count[gi];
  end

endmodule

// File: tb/tb_dyser_port_queue.sv
// Self-checking bench: directed vector table, flush/reset sequences and random traffic vs a queue model.
module tb_dyser_port_queue;
  localparam int DW = 64;
  localparam int NP = 8;
  localparam int DP = 4;
  localparam int NL = 2;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dyser_port_queue_if #(.DATA_W(DW), .NPORT(NP), .DEPTH(DP), .NLANE(NL)) bus ();

  dyser_port_queue #(.DATA_W(DW), .NPORT(NP), .DEPTH(DP), .NLANE(NL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [63:0] mq [NP][$];

  typedef struct {
    logic [1:0]  sen;
    logic [2:0]  sp0, sp1;
    logic [63:0] sd0, sd1;
    logic [1:0]  ren;
    logic [2:0]  rp0, rp1;
    logic        ss, rs;
    logic [63:0] rd0, rd1;
    logic [2:0]  op;
    logic [2:0]  occv;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic [1:0] sen, logic [2:0] sp0, logic [2:0] sp1,
                             logic [63:0] sd0, logic [63:0] sd1,
                             logic [1:0] ren, logic [2:0] rp0, logic [2:0] rp1,
                             logic ss, logic rs, logic [63:0] rd0, logic [63:0] rd1,
                             logic [2:0] op, logic [2:0] occv);
    vec_t r;
    r.sen = sen; r.sp0 = sp0; r.sp1 = sp1; r.sd0 = sd0; r.sd1 = sd1;
    r.ren = ren; r.rp0 = rp0; r.rp1 = rp1; r.ss = ss; r.rs = rs;
    r.rd0 = rd0; r.rd1 = rd1; r.op = op; r.occv = occv;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int p = 0; p < NP; p++) mq[p].delete();
  endtask

  // Called at a falling edge; drives one cycle, checks against the model, advances to the next falling edge.
  task automatic step(input logic [1:0] sen, input logic [2:0] sp0, input logic [2:0] sp1,
                      input logic [63:0] sd0, input logic [63:0] sd1,
                      input logic [1:0] ren, input logic [2:0] rp0, input logic [2:0] rp1,
                      input logic fl,
                      output logic o_ss, output logic o_rs,
                      output logic [63:0] o_rd0, output logic [63:0] o_rd1,
                      output logic [NP*CW-1:0] o_occ);
    int need[NP];
    int want[NP];
    logic [2:0]  sp[2];
    logic [2:0]  rp[2];
    logic [63:0] sd[2];
    logic ess, ers, sov, rov;
    int k;
    sp[0] = sp0; sp[1] = sp1; rp[0] = rp0; rp[1] = rp1; sd[0] = sd0; sd[1] = sd1;
    bus.send_en   = sen;
    bus.send_port = {sp1, sp0};
    bus.send_data = {sd1, sd0};
    bus.recv_en   = ren;
    bus.recv_port = {rp1, rp0};
    bus.flush     = fl;
    #1;
    for (int p = 0; p < NP; p++) begin need[p] = 0; want[p] = 0; end
    for (int i = 0; i < NL; i++) begin
      if (sen[i]) need[sp[i]]++;
      if (ren[i]) want[rp[i]]++;
    end
    sov = 1'b0; rov = 1'b0;
    for (int p = 0; p < NP; p++) begin
      if (need[p] > DP - mq[p].size()) sov = 1'b1;
      if (want[p] > mq[p].size())      rov = 1'b1;
    end
    ess = (sen != 0 && sov) || fl;
    ers = (ren != 0 && rov) || fl;
    chk("send_stall", {63'd0, bus.send_stall}, {63'd0, ess});
    chk("recv_stall", {63'd0, bus.recv_stall}, {63'd0, ers});
    for (int i = 0; i < NL; i++) begin
      if (ren[i] && !ers) begin
        k = 0;
        for (int j = 0; j < i; j++) if (ren[j] && rp[j] == rp[i]) k++;
        chk($sformatf("recv_data%0d", i), bus.recv_data[i*DW +: DW], mq[rp[i]][k]);
      end
    end
    for (int p = 0; p < NP; p++)
      chk($sformatf("occ%0d", p), {61'd0, bus.occ[p*CW +: CW]}, 64'(mq[p].size()));
    o_ss = bus.send_stall; o_rs = bus.recv_stall;
    o_rd0 = bus.recv_data[0 +: DW]; o_rd1 = bus.recv_data[DW +: DW];
    o_occ = bus.occ;
    $display("cyc sen=%b sp=%0d/%0d ren=%b rp=%0d/%0d fl=%b -> ss=%b rs=%b rd0=%h rd1=%h",
             sen, sp0, sp1, ren, rp0, rp1, fl, o_ss, o_rs, o_rd0, o_rd1);
    @(posedge clk);
    if (fl) clear_model();
    else begin
      if (!ers) for (int i = 0; i < NL; i++) if (ren[i]) void'(mq[rp[i]].pop_front());
      if (!ess) for (int i = 0; i < NL; i++) if (sen[i]) mq[sp[i]].push_back(sd[i]);
    end
    @(negedge clk);
  endtask

  logic o_ss, o_rs;
  logic [63:0] o_rd0, o_rd1;
  logic [NP*CW-1:0] o_occ;

  initial begin
    bus.flush = 1'b0; bus.send_en = '0; bus.send_port = '0; bus.send_data = '0;
    bus.recv_en = '0; bus.recv_port = '0;
    clear_model();

    // Reset state.
    #1;
    chk("rst_occ", {40'd0, bus.occ}, 64'd0);
    chk("rst_rdata0", bus.recv_data[0 +: DW], 64'd0);
    chk("rst_rdata1", bus.recv_data[DW +: DW], 64'd0);
    chk("rst_send_stall", {63'd0, bus.send_stall}, 64'd0);
    bus.recv_en = 2'b01;
    #1;
    chk("rst_recv_stall", {63'd0, bus.recv_stall}, 64'd1);
    bus.recv_en = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // sen sp0 sp1 sd0 sd1 | ren rp0 rp1 | ss rs rd0 rd1 | occ port, occ value before the edge
    tbl.push_back(v(1,2,0,'h0,0, 0,0,0, 0,0,0,0, 2,0));
    tbl.push_back(v(1,2,0,'h2,0, 0,0,0, 0,0,0,0, 2,1));
    tbl.push_back(v(1,2,0,'h4,0, 0,0,0, 0,0,0,0, 2,2));
    tbl.push_back(v(1,2,0,'hf,0, 0,0,0, 0,0,0,0, 2,3));
    tbl.push_back(v(0,0,0,0,0, 1,2,0, 0,0,'h0,0, 2,4));
    tbl.push_back(v(0,0,0,0,0, 1,2,0, 0,0,'h2,0, 2,3));
    tbl.push_back(v(0,0,0,0,0, 1,2,0, 0,0,'h4,0, 2,2));
    tbl.push_back(v(0,0,0,0,0, 1,2,0, 0,0,'hf,0, 2,1));
    tbl.push_back(v(0,0,0,0,0, 0,0,0, 0,0,0,0, 2,0));
    tbl.push_back(v(2,0,5,0,'h50, 0,0,0, 0,0,0,0, 5,0));
    tbl.push_back(v(2,0,5,0,'h51, 0,0,0, 0,0,0,0, 5,1));
    tbl.push_back(v(2,0,5,0,'h52, 0,0,0, 0,0,0,0, 5,2));
    tbl.push_back(v(2,0,5,0,'h53, 0,0,0, 0,0,0,0, 5,3));
    tbl.push_back(v(2,0,5,0,'h54, 1,5,0, 1,0,'h50,0, 5,4));
    tbl.push_back(v(2,0,5,0,'h54, 0,0,0, 0,0,0,0, 5,3));
    tbl.push_back(v(0,0,0,0,0, 0,0,0, 0,0,0,0, 5,4));
    tbl.push_back(v(1,3,0,'h30,0, 0,0,0, 0,0,0,0, 3,0));
    tbl.push_back(v(1,3,0,'h31,0, 0,0,0, 0,0,0,0, 3,1));
    tbl.push_back(v(1,3,0,'h32,0, 0,0,0, 0,0,0,0, 3,2));
    tbl.push_back(v(3,3,3,'hA,'hB, 0,0,0, 1,0,0,0, 3,3));
    tbl.push_back(v(0,0,0,0,0, 1,3,0, 0,0,'h30,0, 3,3));
    tbl.push_back(v(3,3,3,'hA,'hB, 0,0,0, 0,0,0,0, 3,2));
    tbl.push_back(v(0,0,0,0,0, 3,3,3, 0,0,'h31,'h32, 3,4));
    tbl.push_back(v(0,0,0,0,0, 3,3,3, 0,0,'hA,'hB, 3,2));
    tbl.push_back(v(0,0,0,0,0, 0,0,0, 0,0,0,0, 3,0));
    tbl.push_back(v(1,4,0,'h7,0, 0,0,0, 0,0,0,0, 4,0));
    tbl.push_back(v(0,0,0,0,0, 3,1,4, 0,1,0,0, 4,1));
    tbl.push_back(v(1,1,0,'h9,0, 3,1,4, 0,1,0,0, 1,0));
    tbl.push_back(v(0,0,0,0,0, 3,1,4, 0,0,'h9,'h7, 4,1));
    tbl.push_back(v(0,0,0,0,0, 0,0,0, 0,0,0,0, 4,0));

    foreach (tbl[n]) begin
      step(tbl[n].sen, tbl[n].sp0, tbl[n].sp1, tbl[n].sd0, tbl[n].sd1,
           tbl[n].ren, tbl[n].rp0, tbl[n].rp1, 1'b0, o_ss, o_rs, o_rd0, o_rd1, o_occ);
      chk($sformatf("tbl%0d_ss", n), {63'd0, o_ss}, {63'd0, tbl[n].ss});
      chk($sformatf("tbl%0d_rs", n), {63'd0, o_rs}, {63'd0, tbl[n].rs});
      if (!tbl[n].rs && tbl[n].ren[0]) chk($sformatf("tbl%0d_rd0", n), o_rd0, tbl[n].rd0);
      if (!tbl[n].rs && tbl[n].ren[1]) chk($sformatf("tbl%0d_rd1", n), o_rd1, tbl[n].rd1);
      chk($sformatf("tbl%0d_occ", n), {61'd0, o_occ[tbl[n].op*CW +: CW]}, {61'd0, tbl[n].occv});
    end

    // Flush concurrent with a send.
    step(3, 0, 6, 'h01, 'h61, 0, 0, 0, 0, o_ss, o_rs, o_rd0, o_rd1, o_occ);
    step(3, 0, 6, 'h02, 'h62, 0, 0, 0, 0, o_ss, o_rs, o_rd0, o_rd1, o_occ);
    step(1, 6, 0, 'hdead, 0, 0, 0, 0, 1, o_ss, o_rs, o_rd0, o_rd1, o_occ);
    chk("flush_ss", {63'd0, o_ss}, 64'd1);
    chk("flush_rs", {63'd0, o_rs}, 64'd1);
    step(0, 0, 0, 0, 0, 1, 6, 0, 0, o_ss, o_rs, o_rd0, o_rd1, o_occ);
    chk("post_flush_occ", {40'd0, o_occ}, 64'd0);
    chk("post_flush_rs", {63'd0, o_rs}, 64'd1);
    step(1, 6, 0, 'h1234, 0, 0, 0, 0, 0, o_ss, o_rs, o_rd0, o_rd1, o_occ);
    step(0, 0, 0, 0, 0, 1, 6, 0, 0, o_ss, o_rs, o_rd0, o_rd1, o_occ);
    chk("post_flush_rd", o_rd0, 64'h1234);

    // Asynchronous reset between edges with words queued.
    step(1, 7, 0, 'h71, 0, 0, 0, 0, 0, o_ss, o_rs, o_rd0, o_rd1, o_occ);
    step(1, 7, 0, 'h72, 0, 0, 0, 0, 0, o_ss, o_rs, o_rd0, o_rd1, o_occ);
    step(1, 7, 0, 'h73, 0, 0, 0, 0, 0, o_ss, o_rs, o_rd0, o_rd1, o_occ);
    bus.send_en = '0; bus.recv_en = 2'b01; bus.recv_port = {3'd0, 3'd7};
    #1;
    chk("pre_rst_rd", bus.recv_data[0 +: DW], 64'h71);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_occ", {40'd0, bus.occ}, 64'd0);
    chk("arst_rd0", bus.recv_data[0 +: DW], 64'd0);
    chk("arst_rd1", bus.recv_data[DW +: DW], 64'd0);
    chk("arst_rs", {63'd0, bus.recv_stall}, 64'd1);
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 1, 7, 0, 0, o_ss, o_rs, o_rd0, o_rd1, o_occ);
    chk("post_rst_rs", {63'd0, o_rs}, 64'd1);

    // Random traffic on a few ports so full, empty and same-port cases recur.
    for (int n = 0; n < 400; n++) begin
      logic [1:0] rsen, rren;
      rsen = 2'($urandom_range(0, 3));
      rren = ($urandom_range(0, 1) != 0) ? 2'($urandom_range(0, 3)) : 2'd0;
      step(rsen, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
           {$urandom, $urandom}, {$urandom, $urandom},
           rren, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
           ($urandom_range(0, 31) == 0),
           o_ss, o_rs, o_rd0, o_rd1, o_occ);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dyser_port_queue.md
Name: dyser_port_queue

Overview:
- Parametrised bank of per-port FIFOs between the core's dyser_send/dyser_recv lanes and the fabric I/O ports.
- Generalises the fixed 2-lane, 8-port, 64-bit send/recv interface to NLANE lanes, NPORT ports, DEPTH entries and DATA_W bits.
- Adds all-or-nothing multi-lane acceptance, same-port multi-lane ordering and a synchronous flush on reconfiguration.
- Each instance sits on one side of the fabric: the input side is filled by core sends, the output side is drained by core receives.

Parameters:
- DATA_W, 64: data word width in bits.
- NPORT, 8: number of ports. Must be a power of 2, ≥2.
- DEPTH, 4: entries per port FIFO. Must be a power of 2, ≥2.
- NLANE, 2: send lanes and recv lanes per cycle, 1..4.
- PORT_W, clog2(NPORT): localparam, port index width.
- CNT_W, clog2(DEPTH)+1: localparam, occupancy counter width.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all FIFOs (asserted with config_en/commit).
- send_en  in  NLANE  per-lane push request.
- send_port  in  NLANE*PORT_W  per-lane target port; lane i occupies bits [i*PORT_W +: PORT_W].
- send_data  in  NLANE*DATA_W  per-lane push data.
- send_stall  out  1  combinational; high means no lane is accepted this cycle.
- recv_en  in  NLANE  per-lane pop request.
- recv_port  in  NLANE*PORT_W  per-lane source port.
- recv_data  out  NLANE*DATA_W  combinational per-lane read data.
- recv_stall  out  1  combinational; high means no lane pops this cycle.
- occ  out  NPORT*CNT_W  per-port occupancy, registered.

Behaviour:
- Storage
  - Each port has a circular buffer with rd_ptr, wr_ptr (log2 DEPTH bits, natural wrap) and a count of 0..DEPTH.
- Reset (rst_n low, asynchronous)
  - All pointers, counts and storage cleared.
  - occ=0 and recv_data=0.
  - send_stall=0 when send_en=0.
  - recv_stall=1 whenever any recv_en is high, since all ports are empty.
- Send acceptance
  - need[p] = number of enabled lanes with send_port==p.
  - send_stall = |send_en && (any p: need[p] > DEPTH-count[p]) || flush.
  - send_stall uses current count only; same-cycle pops do not free space. There is no recv→send combinational path.
  - If send_stall is low, every enabled lane is written on the rising edge.
  - Lanes targeting the same port are enqueued in ascending lane order: lane 0 first.
  - Partial acceptance never occurs.
- Recv
  - want[p] = number of enabled lanes with recv_port==p.
  - recv_stall = |recv_en && (any p: want[p] > count[p]) || flush.
  - recv_data for lane i = entry at rd_ptr[p]+k, where k = number of lower-numbered enabled lanes with the same port. This is first-word fall-through.
  - recv_data is valid whenever recv_stall is low. When recv_stall is high it still shows those entries (stale/undefined content permitted, no X from reset).
  - If recv_stall is low, rd_ptr[p] += want[p] and count decrements by want[p] on the edge.
- Send and recv on the same port in the same cycle
  - Both take effect: count += need - want.
  - A word is never readable in its own push cycle; minimum push→recv latency is 1 cycle.
- Stall independence
  - send_stall does not depend on recv_en, and recv_stall does not depend on send_en.
  - A stalled side is independent of the other side.
- Flush
  - When flush is high at the edge, all counts and pointers go to 0. Any push or pop in that cycle is discarded, and both stalls are high.
  - Storage contents are not cleared.
- Boundaries
  - Full: count==DEPTH, so any lane to that port stalls all sends.
  - Empty: any lane from that port stalls all recvs.
  - Pointer wrap at DEPTH is silent.
  - rst_n asserted mid-transfer aborts it with no completion.
- occ reflects counts after the edge, i.e. one cycle after the transaction.

Decomposition:
- Shared package dyser_pkg
  - DATA_W default, port index type, lane count default.
  - Helper function for clog2.
- Sub-module dyser_port_fifo
  - One port's storage, pointers and count.
  - Multi-write/multi-read by count: inputs wr_cnt, wr_data[NLANE], rd_cnt, clr.
  - Outputs head window[NLANE] and count.
- Top level: per-port need/want counting, stall logic and lane↔port crossbars, as a generate over NPORT.

Test Plan:
1. After reset, with one lane pushing to port 2 and the other lane idle (as a dyser_send1 does): push 0x0, 0x2, 0x4, 0xf to port 2 on lane 0 in consecutive cycles → no send_stall; occ[2]=4; recv lane0 from port 2 returns 0x0, 0x2, 0x4, 0xf in order over 4 cycles with recv_stall=0.
2. Fill port 5 with DEPTH=4 words, then one more send → send_stall=1 and occ[5] stays 4. Same-cycle recv from port 5 still leaves send_stall=1. The next cycle the send is accepted and occ[5]=4.
3. Both lanes send to port 3 with 0xA (lane 0) and 0xB (lane 1) while count[3]=3 → stall, nothing written. With count[3]=2 → both accepted. Two-lane recv from port 3 then returns lane0=0xA, lane1=0xB.
4. Lane0 recv from port 1 (empty) and lane1 recv from port 4 (holding 0x7) → recv_stall=1 and port 4 is not popped. Push 0x9 to port 1 → next cycle recv_stall=0, lane0=0x9, lane1=0x7, both counts decrement.
5. Load ports 0 and 6 with 2 words each, assert flush for one cycle concurrently with a send → all occ=0 and recv_stall=1 afterwards. A subsequent push and recv of 0x1234 to port 6 works.
6. With 3 words queued, drive rst_n low asynchronously between edges → occ and recv_data go to 0 immediately. After release, recv from any port stalls.
